tri_bus_port: RTL and testbench

//  Parametrised, arbitrated tri-state driver for a shared read/data bus.
//  N sources request the bus; a round-robin arbiter grants one at a time.
//  The granted source's word is registered and driven onto the bus; the bus is Z otherwise.
//  A turnaround gap is inserted between owners (break-before-make), so two drivers are never enabled together.

---
 rtl/tri_bus_port.sv | 168 ++++++++++++++++
 tb/tb_tri_bus_port.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tri_bus_port.sv
// tri_bus_port: round-robin arbitrated tri-state bus driver with a break-before-make turnaround gap.
// Define BUS_PARITY_EN to add the even-parity output bus_par, tri-stated together with bus.
module tri_bus_port #(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC-1:0]           req,
  input  logic [NSRC*WIDTH-1:0]     src_data,
  output logic [NSRC-1:0]           grant,
  output logic [$clog2(NSRC)-1:0]   src_sel,
  output logic [WIDTH-1:0]          bus,
  output logic                      bus_oe,
  output logic                      busy
`ifdef BUS_PARITY_EN
  ,
  output logic                      bus_par
`endif
);

  localparam int SW  = $clog2(NSRC);
  localparam int BCW = $clog2(MAX_BURST + 2);
  localparam int TCW = $clog2(TURN_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  localparam logic [BCW-1:0] BURST_MAX  = BCW'(MAX_BURST);
  localparam logic [BCW-1:0] BURST_SAT  = {BCW{1'b1}};
  localparam logic [TCW-1:0] TURN_LOAD  = TCW'(TURN_CYCLES - 1);
  localparam logic [SW-1:0]  LAST_SRC   = SW'(NSRC - 1);

  logic [1:0]       state_q, state_d;
  logic [NSRC-1:0]  grant_q, grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             bus_oe_q, bus_oe_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [TCW-1:0]   turn_cnt_q, turn_cnt_d;

  logic             pick_found_s;
  logic [SW-1:0]    pick_idx_s;
  int               cand_s;
  logic             limit_hit_s;
  logic [WIDTH-1:0] sel_word_s;

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = 0;
    for (int k = 0; k < NSRC; k++) begin
      cand_s = int'(rr_ptr_q) + k;
      if (cand_s >= NSRC) begin
        cand_s = cand_s - NSRC;
      end else begin
        cand_s = cand_s;
      end
      if (!pick_found_s && req[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = SW'(cand_s);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  assign sel_word_s  = src_data[int'(sel_q)*WIDTH +: WIDTH];
  assign limit_hit_s = (MAX_BURST != 0) && (burst_cnt_q == BURST_MAX);

  // Next-state logic for the IDLE/DRIVE/TURN ownership sequence.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    data_d      = data_q;
    bus_oe_d    = bus_oe_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d              = DRIVE;
          grant_d              = '0;
          grant_d[pick_idx_s]  = 1'b1;
          sel_d                = pick_idx_s;
          rr_ptr_d             = (pick_idx_s == LAST_SRC) ? '0 : pick_idx_s + SW'(1);
          burst_cnt_d          = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        // Only the granted word is selected, so other sources never reach data_q.
        if (req[sel_q] && !limit_hit_s) begin
          data_d   = sel_word_s;
          bus_oe_d = 1'b1;
          if (burst_cnt_q != BURST_SAT) begin
            burst_cnt_d = burst_cnt_q + BCW'(1);
          end else begin
            burst_cnt_d = burst_cnt_q;
          end
        end else begin
          state_d    = TURN;
          grant_d    = '0;
          bus_oe_d   = 1'b0;
          turn_cnt_d = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q - TCW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        bus_oe_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset floats the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      data_q      <= '0;
      bus_oe_q    <= 1'b0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      turn_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      bus_oe_q    <= bus_oe_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign src_sel = sel_q;
  assign bus_oe  = bus_oe_q;
  assign busy    = (state_q != IDLE);
  assign bus     = bus_oe_q ? data_q : {WIDTH{1'bz}};

`ifdef BUS_PARITY_EN
  assign bus_par = bus_oe_q ? even_par(data_q) : 1'bz;
`endif

endmodule

// File: tb/tb_tri_bus_port.sv
// Randomized scoreboard bench for tri_bus_port: directed ownership scenarios followed by random request traffic.
module tb_tri_bus_port;
  localparam int WIDTH       = 32;
  localparam int NSRC        = 4;
  localparam int TURN_CYCLES = 2;
  localparam int MAX_BURST   = 3;
  localparam int SW          = $clog2(NSRC);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NSRC-1:0]       req;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       grant;
  logic [SW-1:0]         src_sel;
  logic [WIDTH-1:0]      bus;
  logic                  bus_oe;
  logic                  busy;
`ifdef BUS_PARITY_EN
  logic                  bus_par;
`endif

  tri_bus_port #(.WIDTH(WIDTH), .NSRC(NSRC), .TURN_CYCLES(TURN_CYCLES), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .src_data(src_data), .grant(grant), .src_sel(src_sel),
    .bus(bus), .bus_oe(bus_oe), .busy(busy)
`ifdef BUS_PARITY_EN
    , .bus_par(bus_par)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Reference model: who owns the bus, how long it has driven, Z cycles still owed.
  int   m_owner, m_drives, m_gap, m_ptr, m_sel;
  logic m_oe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_drives = 0; m_gap = 0; m_ptr = 0; m_sel = 0; m_oe = 1'b0;
  endfunction

  function automatic void model_step();
    m_oe = 1'b0;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NSRC; k++) begin
        int i = (m_ptr + k) % NSRC;
        if (m_owner < 0 && req[i]) begin
          m_owner = i; m_sel = i; m_drives = 0; m_ptr = (i + 1) % NSRC;
        end
      end
    end else if (req[m_owner] && (MAX_BURST == 0 || m_drives < MAX_BURST)) begin
      m_drives++;
      m_oe = 1'b1;
      exp_q.push_back(src_data[m_owner*WIDTH +: WIDTH]);
    end else begin
      m_owner = -1;
      m_gap = TURN_CYCLES;
    end
  endfunction

  task automatic check_state();
    logic [NSRC-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("grant", grant, eg);
    check("bus_oe", bus_oe, m_oe);
    check("busy", busy, (m_owner >= 0 || m_gap > 0));
    check("src_sel", src_sel, m_sel);
    check("grant_onehot0", $onehot0(grant), 1'b1);
  endtask

  // One clock: apply inputs, advance the model on the edge, compare just after it.
  task automatic cycle(input logic [NSRC-1:0] r, input logic [NSRC*WIDTH-1:0] d);
    req = r;
    src_data = d;
    @(posedge clk);
    model_step();
    #1;
    check_state();
  endtask

  function automatic logic [NSRC*WIDTH-1:0] rand_data();
    logic [NSRC*WIDTH-1:0] d;
    for (int i = 0; i < NSRC; i++) d[i*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  // Monitor: every driven bus cycle must carry the next expected word.
  always @(negedge clk) begin
    if (!rst && bus_oe) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: got %0h expected no drive at %0t", bus, $time);
      end else begin
        logic [WIDTH-1:0] w;
        w = exp_q.pop_front();
        check("bus_data", bus, w);
`ifdef BUS_PARITY_EN
        check("bus_par", bus_par, ^w);
`endif
      end
    end
  end

  initial begin
    logic [NSRC*WIDTH-1:0] d;
    logic [NSRC-1:0] r;
    int n;
    rst = 1'b1; req = '0; src_data = '0;
    model_reset();
    #12;
    check_state();
    rst = 1'b0;

    // Single source, three held edges then released.
    d = rand_data(); d[0 +: WIDTH] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) cycle(4'b0001, d);
    for (int i = 0; i < 4; i++) cycle(4'b0000, d);

    // Park the pointer at 3, then src0 and src2 compete.
    for (int i = 0; i < 2; i++) cycle(4'b0100, rand_data());
    for (int i = 0; i < 4; i++) cycle(4'b0000, rand_data());
    for (int i = 0; i < 14; i++) cycle(4'b0101, rand_data());
    for (int i = 0; i < 4; i++) cycle(4'b0000, rand_data());

    // All sources held: burst limit forces rotation.
    for (int i = 0; i < 30; i++) cycle(4'b1111, rand_data());
    for (int i = 0; i < 4; i++) cycle(4'b0000, rand_data());

    // Pulse on src1, then reset while driving.
    cycle(4'b0010, rand_data());
    cycle(4'b0000, rand_data());
    for (int i = 0; i < 4; i++) cycle(4'b0000, rand_data());
    d = rand_data(); d[0 +: WIDTH] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) cycle(4'b0001, d);
    #2 rst = 1'b1;
    #1;
    check("rst_bus_oe", bus_oe, 1'b0);
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 1'b0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    req = '0;

    // Random traffic with slowly toggling request levels.
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NSRC; i++) if ($urandom_range(5) == 0) r[i] = ~r[i];
      cycle(r, rand_data());
    end

    // Drain to idle within a bounded number of cycles.
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 20) begin
      cycle(4'b0000, rand_data());
      n++;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
